// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - moving-segment LED bar scanner with programmable step rate
// Head LED plus optional trailing tail; bounce, wrap-left, wrap-right and hold modes.
module led_scanner #(
  parameter int WIDTH    = 8,
  parameter int TRAIL    = 1,
  parameter int PERIOD_W = 24,
  parameter int POS_W    = $clog2(WIDTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [1:0]          i_mode,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_restart,
  output logic [WIDTH-1:0]    o_led,
  output logic [POS_W-1:0]    o_pos,
  output logic                o_step,
  output logic                o_wrap
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [1:0]       MODE_BOUNCE = 2'd0;
  localparam logic [1:0]       MODE_LEFT   = 2'd1;
  localparam logic [1:0]       MODE_RIGHT  = 2'd2;
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic                step_q;
  logic                wrap_q, wrap_d;
  logic                tick;

  // >= lets a lowered period take effect at once instead of waiting for counter rollover
  assign tick = i_en && (cnt_q >= i_period);

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (i_en) begin
      cnt_d = tick ? '0 : cnt_q + PERIOD_W'(1);
    end
    if (tick) begin
      case (i_mode)
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              pos_d  = pos_q - POS_ONE;
              dir_d  = DIR_DOWN;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = POS_ONE;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        MODE_LEFT: begin
          dir_d = DIR_UP;
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end
        MODE_RIGHT: begin
          dir_d = DIR_DOWN;
          if (pos_q == '0) begin
            pos_d  = POS_LAST;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tail trails behind the direction of travel and is clipped at the bar ends
  always_comb begin
    led_d = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (dir_d == DIR_UP) begin
        led_d[k] = (k <= int'(pos_d)) && ((int'(pos_d) - k) < TRAIL);
      end else begin
        led_d[k] = (k >= int'(pos_d)) && ((k - int'(pos_d)) < TRAIL);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      led_q  <= WIDTH'(1);
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (i_restart) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      led_q  <= WIDTH'(1);
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= tick;
      wrap_q <= wrap_d;
    end
  end

  assign o_led  = led_q;
  assign o_pos  = pos_q;
  assign o_step = step_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - scoreboard bench for led_scanner (WIDTH=8, TRAIL=3)
module tb_led_scanner;

  localparam int WIDTH = 8;
  localparam int TRAIL = 3;
  localparam int PW    = 24;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic          restart = 1'b0;
  logic [1:0]    mode    = 2'd0;
  logic [PW-1:0] period  = '0;
  logic [7:0]    led;
  logic [2:0]    pos;
  logic          step;
  logic          wrap;

  led_scanner #(.WIDTH(WIDTH), .TRAIL(TRAIL), .PERIOD_W(PW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_mode   (mode),
    .i_period (period),
    .i_restart(restart),
    .o_led    (led),
    .o_pos    (pos),
    .o_step   (step),
    .o_wrap   (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [2:0] pos;
    logic       step;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt  = 0;
  int   m_pos  = 0;
  bit   m_up   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, want, $time);
    end
  endtask

  function automatic logic [7:0] model_led(input int p, input bit up);
    logic [7:0] l;
    l = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == p) l[k] = 1'b1;
      for (int t = 1; t < TRAIL; t++) begin
        if (up && (k == p - t)) l[k] = 1'b1;
        if (!up && (k == p + t)) l[k] = 1'b1;
      end
    end
    return l;
  endfunction

  // Advance the model with the currently driven inputs, clock once, then score the DUT.
  task automatic cyc();
    exp_t e;
    bit   tick;
    bit   wr;
    tick = en && (m_cnt >= int'(period));
    wr   = 1'b0;
    if (restart) begin
      m_cnt = 0;
      m_pos = 0;
      m_up  = 1'b1;
      tick  = 1'b0;
    end else begin
      if (en) m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) begin
        case (mode)
          2'd0: begin
            if (m_up) begin
              if (m_pos == WIDTH - 1) begin m_pos--; m_up = 1'b0; wr = 1'b1; end
              else m_pos++;
            end else begin
              if (m_pos == 0) begin m_pos++; m_up = 1'b1; wr = 1'b1; end
              else m_pos--;
            end
          end
          2'd1: begin
            m_up = 1'b1;
            if (m_pos == WIDTH - 1) begin m_pos = 0; wr = 1'b1; end
            else m_pos++;
          end
          2'd2: begin
            m_up = 1'b0;
            if (m_pos == 0) begin m_pos = WIDTH - 1; wr = 1'b1; end
            else m_pos--;
          end
          default: begin
          end
        endcase
      end
    end
    e.led  = model_led(m_pos, m_up);
    e.pos  = 3'(m_pos);
    e.step = tick;
    e.wrap = wr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("led", 32'(led), 32'(e.led));
    chk("pos", 32'(pos), 32'(e.pos));
    chk("step", 32'(step), 32'(e.step));
    chk("wrap", 32'(wrap), 32'(e.wrap));
  endtask

  int bseq[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    #12;
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc();

    en = 1'b1; period = '0; mode = 2'd0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("bounce_seq", 32'(pos), 32'(bseq[i]));
      chk("bounce_wrap", 32'(wrap), 32'((i == 7) || (i == 14)));
    end

    period = 24'd3;
    for (int i = 0; i < 8; i++) cyc();
    for (int i = 0; i < 8 && m_cnt != 3; i++) cyc();
    period = 24'd1;
    cyc();
    chk("prescale_force", 32'(step), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("prescale_p1", 32'(step), 32'(i % 2));
    end

    period = '0; mode = 2'd0;
    for (int i = 0; i < 20 && m_pos != 7; i++) cyc();
    mode = 2'd1;
    cyc();
    chk("mix_wrap_pos", 32'(pos), 32'h0);
    chk("mix_wrap_flag", 32'(wrap), 32'h1);
    mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold_pos", 32'(pos), 32'h0);
      chk("hold_step", 32'(step), 32'h1);
    end

    mode = 2'd1;
    cyc();
    mode = 2'd2;
    cyc();
    chk("trail_pos0", 32'(pos), 32'h0);
    chk("trail_led0", 32'(led), 32'h07);
    cyc();
    chk("trail_pos7", 32'(pos), 32'h7);
    chk("trail_led7", 32'(led), 32'h80);
    chk("trail_wrap", 32'(wrap), 32'h1);

    mode = 2'd1;
    for (int i = 0; i < 20 && m_pos != 5; i++) cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_pos", 32'(pos), 32'h0);
    chk("restart_led", 32'(led), 32'h01);
    chk("restart_step", 32'(step), 32'h0);

    period = 24'd4;
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("en_low_step", 32'(step), 32'h0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("en_resume", 32'(step), 32'(i == 2));
    end

    period = '0; mode = 2'd0;
    for (int i = 0; i < 3; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'h01);
    chk("async_pos", 32'(pos), 32'h0);
    chk("async_step", 32'(step), 32'h0);
    m_cnt = 0; m_pos = 0; m_up = 1'b1;
    en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
